// File: rtl/alu_pkg.sv
// Shared ALU / mul-div definitions: opcodes, FSM state type, decode helpers.
package alu_pkg;

  localparam logic [7:0] OP_MUL    = 8'd10;
  localparam logic [7:0] OP_MULH   = 8'd11;
  localparam logic [7:0] OP_MULHSU = 8'd12;
  localparam logic [7:0] OP_MULHU  = 8'd13;
  localparam logic [7:0] OP_DIV    = 8'd14;
  localparam logic [7:0] OP_DIVU   = 8'd15;
  localparam logic [7:0] OP_REM    = 8'd16;
  localparam logic [7:0] OP_REMU   = 8'd17;
  localparam logic [7:0] OP_MULW   = 8'd38;
  localparam logic [7:0] OP_DIVW   = 8'd39;
  localparam logic [7:0] OP_DIVUW  = 8'd40;
  localparam logic [7:0] OP_REMW   = 8'd41;
  localparam logic [7:0] OP_REMUW  = 8'd42;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

  // Which slice of the iteration register becomes the result.
  typedef enum logic [1:0] {SEL_MUL_LO, SEL_MUL_HI, SEL_QUO, SEL_REM} res_sel_t;

  function automatic logic is_word_op(input logic [7:0] op);
    return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  // rs1 is interpreted as signed (rs2 too, except for MULHSU).
  function automatic logic is_signed_op(input logic [7:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic is_md_op(input logic [7:0] op);
    return op inside {[OP_MUL:OP_REMU], [OP_MULW:OP_REMUW]};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: one 2*XLEN shift register, one shared add/sub, down counter.
// Multiply: shift-add right, {hi,lo} starts as {0, multiplier}.
// Divide: restoring, shift left, {hi,lo} starts as {0, dividend}; ends {rem, quo}.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              clear,
  input  logic              is_div,
  input  logic              word,
  input  logic [XLEN-1:0]   opa,     // multiplicand or divisor magnitude
  input  logic [XLEN-1:0]   opb,     // multiplier or dividend magnitude
  output logic              last,
  output logic [2*XLEN-1:0] acc
);

  localparam int CW  = $clog2(XLEN + 1);
  localparam int WSH = XLEN - 32;

  logic [CW-1:0]     cnt;
  logic              div_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   hi, lo;
  logic [XLEN:0]     add_a, add_b, sum;
  logic              cin;
  logic [2*XLEN-1:0] nxt;

  assign hi   = acc[2*XLEN-1:XLEN];
  assign lo   = acc[XLEN-1:0];
  assign last = (cnt == CW'(1));

  // Shared adder: accumulate for multiply, trial subtract for divide.
  always_comb begin
    if (div_q) begin
      add_a = {hi, lo[XLEN-1]};
      add_b = ~{1'b0, a_q};
      cin   = 1'b1;
    end else begin
      add_a = {1'b0, hi};
      add_b = lo[0] ? {1'b0, a_q} : '0;
      cin   = 1'b0;
    end
    sum = add_a + add_b + {{XLEN{1'b0}}, cin};
  end

  // Next register value for one iteration.
  always_comb begin
    if (div_q)
      nxt = sum[XLEN] ? {add_a[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                      : {sum[XLEN-1:0],   lo[XLEN-2:0], 1'b1};
    else
      nxt = {sum, lo[XLEN-1:1]};
  end

  // Load on start, then iterate until the counter drains.
  // Word divides pre-shift the dividend so 32 steps consume its bits MSB first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      div_q <= 1'b0;
      a_q   <= '0;
      acc   <= '0;
    end else if (start) begin
      cnt   <= word ? CW'(32) : CW'(XLEN);
      div_q <= is_div;
      a_q   <= opa;
      acc   <= {{XLEN{1'b0}}, (is_div && word) ? (opb << WSH) : opb};
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      acc <= nxt;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV64M multiply/divide unit: handshakes, decode, special cases, sign fix-up.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  muldiv_state_t     state;
  logic              accept, special, core_last;
  logic [2*XLEN-1:0] acc;

  logic              word, legal, is_mul, is_rem, mul_hi, sgn_a, sgn_b;
  logic              neg_a, neg_b, div_zero, ovf;
  logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, dvd, spec_res;

  logic              word_q, neg_q;
  res_sel_t          sel_q, sel_d;
  logic [TAG_W-1:0]  tag_q;

  assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;

  // Decode, operand extension, magnitudes and 1-cycle special results.
  always_comb begin
    word   = (XLEN == 64) && is_word_op(in_op);
    legal  = is_md_op(in_op) && (XLEN == 64 || !is_word_op(in_op));
    is_mul = in_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    is_rem = in_op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    mul_hi = in_op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    sgn_a  = is_signed_op(in_op);
    sgn_b  = sgn_a && (in_op != OP_MULHSU);

    ext_a  = word ? (sgn_a ? sext32(in_rs1[31:0]) : XLEN'(in_rs1[31:0])) : in_rs1;
    ext_b  = word ? (sgn_b ? sext32(in_rs2[31:0]) : XLEN'(in_rs2[31:0])) : in_rs2;
    neg_a  = sgn_a && ext_a[XLEN-1];
    neg_b  = sgn_b && ext_b[XLEN-1];
    mag_a  = neg_a ? -ext_a : ext_a;
    mag_b  = neg_b ? -ext_b : ext_b;

    dvd      = word ? sext32(in_rs1[31:0]) : in_rs1;
    div_zero = !is_mul && (ext_b == '0);
    ovf      = !is_mul && sgn_a && (&ext_b) &&
               (word ? (in_rs1[31:0] == 32'h8000_0000)
                     : (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}));
    special  = !legal || div_zero || ovf;

    if (!legal)        spec_res = '0;
    else if (div_zero) spec_res = is_rem ? dvd : '1;
    else if (ovf)      spec_res = is_rem ? '0 : dvd;
    else               spec_res = '0;

    if (is_mul) sel_d = mul_hi ? SEL_MUL_HI : SEL_MUL_LO;
    else        sel_d = is_rem ? SEL_REM : SEL_QUO;
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && !special),
    .clear   (flush),
    .is_div  (!is_mul),
    .word    (word),
    .opa     (is_mul ? mag_a : mag_b),
    .opb     (is_mul ? mag_b : mag_a),
    .last    (core_last),
    .acc     (acc)
  );

  logic [2*XLEN-1:0] prod, prod_n;
  logic [XLEN-1:0]   quo, rem, fix_raw, fix_res;

  // Sign correction and W sign-extension of the finished iteration.
  always_comb begin
    prod    = word_q ? (acc >> (XLEN - 32)) : acc;
    prod_n  = neg_q ? -prod : prod;
    quo     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem     = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (sel_q)
      SEL_MUL_LO: fix_raw = prod_n[XLEN-1:0];
      SEL_MUL_HI: fix_raw = prod_n[2*XLEN-1:XLEN];
      SEL_QUO:    fix_raw = quo;
      default:    fix_raw = rem;
    endcase
    fix_res = word_q ? sext32(fix_raw[31:0]) : fix_raw;
  end

  // Control FSM with registered result/handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      word_q     <= 1'b0;
      neg_q      <= 1'b0;
      sel_q      <= SEL_MUL_LO;
      tag_q      <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            word_q <= word;
            sel_q  <= sel_d;
            neg_q  <= (sel_d == SEL_REM) ? neg_a : (neg_a ^ neg_b);
            tag_q  <= in_tag;
            if (special) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= spec_res;
              out_tag    <= in_tag;
            end else begin
              state     <= CALC;
              out_valid <= 1'b0;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        CALC: if (core_last) state <= FIX;
        FIX: begin
          state      <= DONE;
          out_valid  <= 1'b1;
          out_result <= fix_res;
          out_tag    <= tag_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=64): directed table, corner
// sequences, and random ops against an arithmetic reference model.
module tb_muldiv_unit;
  import alu_pkg::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0]       in_op;
  logic [XLEN-1:0]  in_rs1, in_rs2, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  typedef struct {
    logic [7:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference result straight from the RV64M arithmetic rules.
  function automatic logic [63:0] model(input logic [7:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [128:0] sa, sb, sp;
    logic [127:0]        up;
    logic signed [63:0]  s1, s2;
    logic signed [31:0]  w1, w2;
    logic [31:0]         u1, u2, wr;
    s1 = a; s2 = b; w1 = a[31:0]; w2 = b[31:0]; u1 = a[31:0]; u2 = b[31:0];
    wr = '0;
    case (op)
      OP_MUL:    return a * b;
      OP_MULH:   begin sa = s1; sb = s2; sp = sa * sb; return sp[127:64]; end
      OP_MULHSU: begin sa = s1; sb = {65'd0, b}; sp = sa * sb; return sp[127:64]; end
      OP_MULHU:  begin up = {64'd0, a} * {64'd0, b}; return up[127:64]; end
      OP_DIV:    return (b == 0) ? ONES : (a == MINV && b == ONES) ? a : 64'(s1 / s2);
      OP_REM:    return (b == 0) ? a : (a == MINV && b == ONES) ? 64'd0 : 64'(s1 % s2);
      OP_DIVU:   return (b == 0) ? ONES : a / b;
      OP_REMU:   return (b == 0) ? a : a % b;
      OP_MULW:   wr = u1 * u2;
      OP_DIVW:   wr = (w2 == 0) ? 32'hFFFF_FFFF :
                      (u1 == 32'h8000_0000 && w2 == -1) ? u1 : 32'(w1 / w2);
      OP_REMW:   wr = (w2 == 0) ? u1 :
                      (u1 == 32'h8000_0000 && w2 == -1) ? 32'd0 : 32'(w1 % w2);
      OP_DIVUW:  wr = (u2 == 0) ? 32'hFFFF_FFFF : u1 / u2;
      OP_REMUW:  wr = (u2 == 0) ? u1 : u1 % u2;
      default:   return 64'd0;
    endcase
    return {{32{wr[31]}}, wr};
  endfunction

  // Edges after the accepting edge until out_valid is seen.
  function automatic int model_lat(input logic [7:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
    logic w, sdiv;
    w    = op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    sdiv = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    if (!(op inside {[8'd10:8'd17], [8'd38:8'd42]})) return 0;
    if (!(op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW})) begin
      if (w ? (b[31:0] == 0) : (b == 0)) return 0;
      if (sdiv && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == MINV && b == ONES))) return 0;
    end
    return w ? 33 : 65;
  endfunction

  // Issue one op (called #1 after a posedge), wait for result, consume it.
  task automatic do_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, output logic [63:0] res,
                       output logic [4:0] rtag, output int lat);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    res = out_result; rtag = out_tag;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return ONES;
      2: return MINV;
      3: return 64'($urandom_range(0, 20));
      4: return {32'h0, $urandom};
      5: return {{32{1'b1}}, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  vec_t       tv[15];
  logic [7:0] ops[14];
  logic [63:0] res;
  logic [4:0]  rtag;
  int          lat;

  initial begin
    tv[0]  = '{OP_DIV,    64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 65};
    tv[1]  = '{OP_REM,    64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 65};
    tv[2]  = '{OP_DIVU,   64'd7, 64'd0, ONES, 0};
    tv[3]  = '{OP_REMU,   64'd7, 64'd0, 64'd7, 0};
    tv[4]  = '{OP_DIV,    MINV, ONES, MINV, 0};
    tv[5]  = '{OP_REM,    MINV, ONES, 64'd0, 0};
    tv[6]  = '{OP_MULHU,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    tv[7]  = '{OP_MULH,   ONES, ONES, 64'd0, 65};
    tv[8]  = '{OP_MUL,    ONES, ONES, 64'd1, 65};
    tv[9]  = '{OP_MULHSU, ONES, 64'd2, ONES, 65};
    tv[10] = '{OP_DIVW,   64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0};
    tv[11] = '{OP_MULW,   64'h1_0000, 64'h1_0000, 64'd0, 33};
    tv[12] = '{OP_DIVUW,  64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    tv[13] = '{8'd5,      64'd123, 64'd456, 64'd0, 0};
    tv[14] = '{OP_REMW,   64'hFFFF_FFF9, 64'd2, ONES, 33};
    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW, 8'd20};

    reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, 5'(i + 1), res, rtag, lat);
      chk($sformatf("tv%0d_result", i), res, tv[i].exp);
      chk($sformatf("tv%0d_tag", i), 64'(rtag), 64'(i + 1));
      chk($sformatf("tv%0d_latency", i), 64'(lat), 64'(tv[i].lat));
    end

    // Hold result while consumer stalls, then back-to-back issue.
    in_valid = 1'b1; in_op = OP_DIV; in_rs1 = 64'd20; in_rs2 = 64'hFFFF_FFFF_FFFF_FFFD;
    in_tag = 5'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("hold_latency", 64'(lat), 64'd65);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", out_result, model(OP_DIV, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD));
      chk("hold_tag", 64'(out_tag), 64'd7);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_op = OP_MUL; in_rs1 = 64'd3; in_rs2 = 64'd5;
    in_tag = 5'd9;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_gap_valid", 64'(out_valid), 64'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("b2b_latency", 64'(lat), 64'd65);
    chk("b2b_result", out_result, 64'd15);
    chk("b2b_tag", 64'(out_tag), 64'd9);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush mid-divide; a simultaneous request must be dropped.
    in_valid = 1'b1; in_op = OP_DIV; in_rs1 = 64'd1000; in_rs2 = 64'd7; in_tag = 5'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; in_op = OP_DIVU; in_rs1 = 64'd7; in_rs2 = 64'd0;
    in_tag = 5'd3;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush_in_ready_t7", 64'(in_ready), 64'd1);
    lat = 0;
    for (int c = 0; c < 80; c++) begin
      if (out_valid) lat++;
      @(posedge clk); #1;
    end
    chk("flush_no_result", 64'(lat), 64'd0);

    // Asynchronous reset mid-CALC.
    chk("pre_rst_result", out_result, 64'd15);
    in_valid = 1'b1; in_op = OP_DIV; in_rs1 = 64'd100; in_rs2 = 64'd7; in_tag = 5'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_result", out_result, 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    for (int c = 0; c < 80; c++) begin
      if (out_valid) lat++;
      @(posedge clk); #1;
    end
    chk("arst_no_result", 64'(lat), 64'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  op;
      logic [63:0] a, b;
      op = ops[$urandom_range(0, 13)];
      a  = rnd64();
      b  = rnd64();
      do_op(op, a, b, 5'($urandom), res, rtag, lat);
      chk($sformatf("rnd%0d_op%0d_result", i, op), res, model(op, a, b));
      chk($sformatf("rnd%0d_op%0d_latency", i, op), 64'(lat), 64'(model_lat(op, a, b)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle, parametrised RV64M multiply/divide unit in the execute stage, beside the single-cycle ALU. It takes the ALU's M-extension opcodes (MUL…REMU, MULW…REMUW) and runs them iteratively, one bit per cycle. Operands and results move over valid/ready handshakes, and a tag is carried through with each operation. Divide-by-zero and signed-overflow cases follow the RISC-V spec, and a flush input supports pipeline squashes.

## Interface
Parameters:
- XLEN, 64, datapath width; must be 32 or 64 (W ops are only legal when XLEN=64).
- TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  8  ALU opcode, using the ALU's 8-bit instruction codes: 10–17, 38–42.
- in_rs1, in_rs2  in  XLEN  operand values.
- in_tag  in  TAG_W  tag, returned unchanged with the result.
- flush  in  1  discard the in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.

## Operation
States:
- IDLE: in_ready=1.
- CALC: N iterations, counter counts down.
- FIX: sign correction and W sign-extension.
- DONE: out_valid=1, result held until accepted.

Transitions:
- Accept when in_valid && in_ready. Latch op, tag and operand magnitudes.
- Normal case: IDLE→CALC.
- Special cases go IDLE→DONE, skipping CALC and FIX.
- DONE→IDLE when out_ready=1, or DONE→DONE if a new request is accepted in the same cycle. in_ready is high in DONE only when out_ready=1.

Iteration count:
- N=XLEN for 64-bit ops.
- N=32 for W ops; operands are rs1[31:0] and rs2[31:0], sign- or zero-extended as the op requires.

Multiply:
- Unsigned shift-add on |a|, |b| into a 2·XLEN product register.
- MUL returns the low half. MULH, MULHSU and MULHU return the high half.
- FIX negates the full product when the sign of the true product is negative (MULHSU: rs1 is signed, rs2 unsigned).

Divide:
- Restoring divide on magnitudes.
- FIX negates the quotient if the operand signs differ, and negates the remainder to match the dividend's sign.

Special cases (1-cycle path):
- Divisor zero: quotient = all ones; remainder = dividend. For W ops the remainder is the sign-extended low 32 bits of the dividend.
- Signed overflow (most-negative ÷ −1): quotient = dividend; remainder = 0.
- Unsupported opcode: accepted, result 0.

Result rules:
- All W results are sign-extended from bit 31, including DIVUW and REMUW.

Flush:
- Any state → IDLE next cycle. out_valid is 0 that cycle and no result is produced.
- in_ready=0 during the flush cycle. flush wins over a simultaneous in_valid (request not accepted) and over a simultaneous out_ready.

## Timing
Reset values:
- State = IDLE; in_ready=1.
- out_valid=0, out_result=0, out_tag=0.

Latency (accept in cycle t):
- Normal ops: out_valid rises at t+N+2 (t+66 for 64-bit ops, t+34 for W ops).
- Special cases: out_valid rises at t+1.

Output handshake:
- out_result and out_tag are registered and stay stable while out_valid && !out_ready.
- Reset asserted mid-operation clears state immediately, with no result emitted.

Throughput:
- One operation in flight at a time.
- Back-to-back issue is allowed: a request accepted in the cycle the previous result is accepted enters CALC the next cycle.

## Structure
Shared package alu_pkg holds:
- The opcode localparams shared with the ALU (OP_MUL=10 … OP_REMU=17, OP_MULW=38 … OP_REMUW=42).
- The muldiv_state_t enum (IDLE, CALC, FIX, DONE).
- Helpers is_word_op() and is_signed_op().

One sub-module, muldiv_core, holds the shared 2·XLEN shift register and adder/subtractor, plus the iteration counter. muldiv_unit holds the FSM, the handshakes, special-case detection and FIX.

## Test plan
All values for XLEN=64.
- DIV rs1=20, rs2=−3 → out_result 0xFFFF_FFFF_FFFF_FFFA. REM same operands → 2. out_valid at t+66.
- DIVU 7/0 → 0xFFFF_FFFF_FFFF_FFFF at t+1. REMU 7/0 → 7. DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000. REM same operands → 0.
- MULHU all-ones×all-ones → 0xFFFF_FFFF_FFFF_FFFE. MULH −1×−1 → 0. MUL −1×−1 → 1. MULHSU −1×2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW rs1=0x0000_0000_8000_0000, rs2=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 at t+1. MULW 0x10000×0x10000 → 0 at t+34. DIVUW 0xFFFF_FFFE/1 → 0xFFFF_FFFF_FFFF_FFFE.
- Hold out_ready=0 for 10 cycles in DONE → out_result and out_tag stable, in_ready=0. Then out_ready=1 together with a new in_valid → the new op is accepted and its out_valid rises 66 cycles later.
- Flush at t+5 of a DIV → no out_valid, in_ready=1 at t+7. Drop reset_n low mid-CALC → outputs return to reset values asynchronously.
